l3_port_arbiter: RTL and testbench
==================================

Name: l3_port_arbiter

Overview:
- Shares the single byte-wide L3 port between N word requesters: per-core fetch units and load/store units.
- Grants one requester at a time, round-robin.
- Sequences each 32-bit request into four little-endian byte accesses: byte at addr holds bits [7:0], addr+3 holds bits [31:24].
- Returns one response pulse to the granted requester.
- Sits between the cores (instruction fetch, data access) and the L3 memory array.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, byte address width of the L3.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request; held with fields stable until accepted.
- req_ready  out  N_REQ  one-hot accept; handshake when req_valid[i] && req_ready[i].
- req_we  in  N_REQ  1 = write word, 0 = read word.
- req_addr  in  N_REQ*ADDR_W  byte address, requester i at slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*32  write data, requester i at slice [i*32 +: 32].
- resp_valid  out  N_REQ  one-cycle completion pulse to the owning requester.
- resp_rdata  out  32  read word, shared; meaningful only while any resp_valid is high.
- resp_err  out  1  error flag qualified by resp_valid.
- mem_en  out  1  L3 byte access strobe.
- mem_we  out  1  L3 byte write.
- mem_addr  out  ADDR_W  L3 byte address.
- mem_wdata  out  8  L3 write byte.
- mem_rdata  in  8  L3 read byte; valid the cycle after mem_en with mem_we=0 (synchronous read, 1-cycle latency).

Behaviour:
- FSM states: IDLE, XFER, DRAIN, RESP.
- Reset values: state=IDLE, rr_last=N_REQ-1, so requester 0 wins first.
  - All outputs 0: req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_addr, mem_wdata.
- IDLE:
  - req_ready is combinational from req_valid.
  - Winner is the first valid index searching rr_last+1, rr_last+2, ... modulo N_REQ.
  - req_ready=0 outside IDLE or when no req_valid.
  - On handshake (cycle T): latch owner, we, addr, wdata; rr_last<=owner; beat<=0; go to XFER.
- XFER, cycles T+1..T+4, beat 0..3:
  - mem_en=1, mem_we=latched we, mem_addr=addr+beat (ADDR_W modulo wrap, e.g. 0xFFFE -> 0xFFFE,0xFFFF,0x0000,0x0001).
  - mem_wdata=wdata[8*beat+:8].
  - Read bytes are captured one cycle after issue into rdata[8*(beat-1)+:8].
  - After beat 3, go to DRAIN.
- DRAIN (T+5): mem_en=0; capture byte 3 on reads; go to RESP.
- RESP (T+6):
  - resp_valid[owner]=1 for exactly one cycle.
  - resp_rdata=assembled word on reads, 0 on writes; resp_err=0.
  - Next state IDLE.
- Outside RESP: resp_valid=0 and resp_rdata=0.
- Latency and throughput:
  - Fixed 6 cycles from handshake to resp_valid for both reads and writes.
  - Next handshake no earlier than T+7, giving one request per 7 cycles.
- Fairness: a continuously requesting set is served strictly in rotating order. No requester waits more than N_REQ-1 transactions.
- req_valid dropped before accept: allowed; the arbiter re-evaluates each IDLE cycle.
- Reset mid-operation: immediate return to reset state.
  - No resp_valid is ever produced for the aborted request.
  - Partially written bytes remain in L3.

Optional Feature:
- Macro L3_ARB_ALIGN_CHECK_EN.
- Defined: a request with addr[1:0]!=0 is accepted normally but skips XFER/DRAIN.
  - It goes to RESP at T+1 with resp_err=1 and resp_rdata=0.
  - mem_en stays 0, so L3 is untouched.
- Undefined: alignment is not checked, resp_err is tied to 0, and misaligned words are sequenced as four consecutive bytes with wrap.

Test Plan:
- Read word: preload L3[0..3]=15,21,40,11; req0 read addr 0 -> req_ready[0] at T, mem_en T+1..T+4 with addr 0..3, resp_valid[0] at T+6, resp_rdata=0x11402115.
- Write then read: req1 write 0xDEADBEEF to addr 8 -> L3[8..11]=EF,BE,AD,DE; req1 read addr 8 -> 0xDEADBEEF.
- Contention: req0, req2 and req3 all valid from reset -> grants 0,2,3,0,2,3; handshakes exactly 7 cycles apart; each resp_valid goes only to its owner.
- Wrap: ADDR_W=16, write 0x04030201 at addr 0xFFFE (macro off) -> L3[FFFE]=01, L3[FFFF]=02, L3[0000]=03, L3[0001]=04.
- Reset mid-operation: assert rst at T+3 of a read -> next cycle mem_en=0, state IDLE, no resp_valid; the next grant goes to requester 0.
- With L3_ARB_ALIGN_CHECK_EN: read addr 0x0005 -> resp_valid at T+1, resp_err=1, resp_rdata=0, mem_en never asserted.

Source files
------------

// File: rtl/l3_port_arbiter.sv
// l3_port_arbiter: round-robin word-to-byte sequencer onto the L3 port; `define L3_ARB_ALIGN_CHECK_EN to fault misaligned words
module l3_port_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*32-1:0]     req_wdata,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;
  state_t            state, state_n;
  logic [IW-1:0]     rr_last, owner, win;
  logic              we, err, hs, mis, sel_we;
  logic [ADDR_W-1:0] addr, sel_addr;
  logic [31:0]       wdata, rdata, sel_wdata;
  logic [1:0]        beat;
  // winner is the valid requester closest after rr_last in rotating order
  always_comb begin
    int best;
    best = N_REQ;
    win = '0;
    for (int i = 0; i < N_REQ; i++)
      if (req_valid[i] && (i + N_REQ - 1 - int'(rr_last)) % N_REQ < best) begin
        best = (i + N_REQ - 1 - int'(rr_last)) % N_REQ;
        win = IW'(i);
      end
  end
  // selected request fields and handshake/alignment qualifiers
  always_comb begin
    hs = state == IDLE && |req_valid && !rst;
    sel_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[int'(win)*32 +: 32];
    sel_we = req_we[win];
`ifdef L3_ARB_ALIGN_CHECK_EN
    mis = sel_addr[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
  end
  // next state and all port outputs, decoded from the current state
  always_comb begin
    state_n = state == IDLE  ? (hs ? (mis ? RESP : XFER) : IDLE)
            : state == XFER  ? (beat == 2'd3 ? DRAIN : XFER)
            : state == DRAIN ? RESP : IDLE;
    req_ready = hs ? N_REQ'(1) << win : '0;
    mem_en = state == XFER;
    mem_we = mem_en && we;
    mem_addr = mem_en ? addr + ADDR_W'(beat) : '0;
    mem_wdata = mem_en ? wdata[8*beat +: 8] : '0;
    resp_valid = state == RESP ? N_REQ'(1) << owner : '0;
    resp_rdata = (state == RESP && !we && !err) ? rdata : '0;
    resp_err = state == RESP && err;
  end
  // state register, latched request, beat counter and read byte assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_last <= IW'(N_REQ - 1);
      owner <= '0;
      we <= 1'b0;
      err <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      beat <= '0;
    end else begin
      state <= state_n;
      if (hs) begin
        owner <= win;
        rr_last <= win;
        we <= sel_we;
        err <= mis;
        addr <= sel_addr;
        wdata <= sel_wdata;
        rdata <= '0;
        beat <= '0;
      end
      if (state == XFER) begin
        beat <= beat + 2'd1;
        if (!we && beat != 2'd0) rdata[8*(beat-2'd1) +: 8] <= mem_rdata;
      end
      if (state == DRAIN && !we) rdata[31:24] <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_l3_port_arbiter.sv
// tb_l3_port_arbiter: scoreboard bench with a byte-wide synchronous L3 model
module tb_l3_port_arbiter;
  localparam int N = 4, AW = 16;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid, req_ready, req_we, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [31:0] resp_rdata, last_rdata;
  logic resp_err, mem_en, mem_we;
  logic [AW-1:0] mem_addr, ma;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  int n_vec = 0, n_err = 0, cyc = 0;
  typedef struct {int idx; logic [31:0] data; logic err; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  int gnt[$];
  int gnt_t[$];

  l3_port_arbiter #(.N_REQ(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          ma = req_addr[i*AW +: AW];
          e.idx = i; e.err = 1'b0; e.due = cyc + 6; e.data = '0;
`ifdef L3_ARB_ALIGN_CHECK_EN
          if (ma[1:0] != 2'b00) begin e.err = 1'b1; e.due = cyc + 1; end
`endif
          if (!e.err)
            for (int b = 0; b < 4; b++)
              if (req_we[i]) ref_mem[ma + 16'(b)] = req_wdata[i*32 + 8*b +: 8];
              else e.data[8*b +: 8] = ref_mem[ma + 16'(b)];
          sb.push_back(e);
          gnt.push_back(i);
          gnt_t.push_back(cyc);
        end
      if (|resp_valid) begin
        if (sb.size() == 0) check("spurious_resp", resp_valid, 0);
        else begin
          e = sb.pop_front();
          check("resp_owner", resp_valid, 64'(1) << e.idx);
          check("resp_rdata", resp_rdata, e.data);
          check("resp_err", resp_err, e.err);
          check("resp_latency", cyc, e.due);
          last_rdata = resp_rdata;
        end
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic issue(input int i, input logic w, input logic [15:0] a, input logic [31:0] d);
    req_we[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*32 +: 32] = d;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    check("req_ready", req_ready[i], 1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_g[6] = '{0, 2, 3, 0, 2, 3};
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    poke(16'h0, 8'h15); poke(16'h1, 8'h21); poke(16'h2, 8'h40); poke(16'h3, 8'h11);
    for (int a = 16'h20; a < 16'h70; a++) poke(16'(a), 8'(a * 7));
    repeat (3) @(posedge clk);
    #1 check("rst_outs_a", {req_ready, resp_valid, resp_rdata, resp_err}, 0);
    check("rst_outs_b", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    rst = 0;
    @(posedge clk);
    #1 check("idle_outs", {req_ready, resp_valid, mem_en, mem_addr}, 0);
    issue(0, 1'b0, 16'h0, 32'h0);
    for (int b = 0; b < 4; b++) begin
      check("beat_en", {mem_en, mem_we}, 2'b10);
      check("beat_addr", mem_addr, 64'(b));
      @(posedge clk);
      #1;
    end
    check("drain_en", mem_en, 0);
    drain();
    check("rd_word", last_rdata, 32'h11402115);
    issue(1, 1'b1, 16'h8, 32'hDEADBEEF);
    check("wr_beat0", {mem_we, mem_wdata}, 9'h1EF);
    drain();
    check("wr_mem", {mem[11], mem[10], mem[9], mem[8]}, 32'hDEADBEEF);
    issue(1, 1'b0, 16'h8, 32'h0);
    drain();
    check("rd_back", last_rdata, 32'hDEADBEEF);
`ifndef L3_ARB_ALIGN_CHECK_EN
    issue(2, 1'b1, 16'hFFFE, 32'h04030201);
    drain();
    check("wrap_mem", {mem[16'h1], mem[16'h0], mem[16'hFFFF], mem[16'hFFFE]}, 32'h04030201);
`endif
    rst = 1;
    req_we = '0;
    req_addr = {16'h60, 16'h40, 16'h0, 16'h20};
    req_valid = 4'b1101;
    repeat (2) @(posedge clk);
    #1 check("rst_ready", req_ready, 0);
    gnt.delete(); gnt_t.delete();
    rst = 0;
    for (int k = 0; k < 100 && gnt.size() < 6; k++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = '0;
    drain();
    check("gnt_count", gnt.size(), 6);
    for (int j = 0; j < 6 && j < gnt.size(); j++) begin
      check("gnt_order", gnt[j], exp_g[j]);
      if (j > 0) check("gnt_spacing", gnt_t[j] - gnt_t[j-1], 7);
    end
    issue(1, 1'b0, 16'h20, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 check("rst_mid_mem_en", mem_en, 0);
    check("rst_mid_resp", resp_valid, 0);
    rst = 0;
    repeat (10) @(posedge clk);
    #1 gnt.delete();
    req_addr = {16'h60, 16'h40, 16'h0, 16'h20};
    req_valid = 4'b0101;
    for (int k = 0; k < 20 && gnt.size() < 1; k++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = '0;
    check("rst_next_gnt", gnt.size() > 0 ? gnt[0] : -1, 0);
    drain();
`ifdef L3_ARB_ALIGN_CHECK_EN
    issue(3, 1'b0, 16'h5, 32'h0);
    check("mis_no_mem", mem_en, 0);
    check("mis_resp_t1", {resp_valid, resp_err}, 5'b10001);
    drain();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
